// File: rtl/uio_bus_pkg.sv
// Shared encodings for the uio strobe/acknowledge register-access bus.
package uio_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmdHold,
        StWrWait,
        StWrHold,
        StRdReq,
        StRdWait,
        StRdDrive,
        StRdTurn
    } state_e;

    localparam int unsigned CMD_WR_BIT = 7;

    localparam logic [7:0] OE_DRIVE = 8'hFF;
    localparam logic [7:0] OE_REL   = 8'h00;

endpackage

// File: rtl/stb_sync.sv
// Host strobe synchronizer with a delay flop for edge detection; edges are masked while ena=0
// but the flops keep tracking so no stale edge appears when ena returns.
module stb_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic stb,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            d_q  <= 1'b0;
        end else begin
            s1_q <= stb;
            s2_q <= s1_q;
            d_q  <= s2_q;
        end
    end

    assign rise = ena & s2_q & ~d_q;
    assign fall = ena & ~s2_q & d_q;

endmodule

// File: rtl/uio_bus_ctrl.sv
// Sequences the bidirectional uio pins as a strobe/acknowledge register bus: command decode,
// write/read pulses to the register file, and output-enable turnaround.
module uio_bus_ctrl
    import uio_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              host_stb,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic              host_ack,
    output logic              host_err,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_rvalid,
    output logic              busy
);

    // Expiry fires on the last cycle of 2**TMO_W-1 cycles spent in one state.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    logic rise;
    logic fall;

    stb_sync u_stb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .stb   (host_stb),
        .rise  (rise),
        .fall  (fall)
    );

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [7:0]        oe_q, oe_d;
    logic [7:0]        out_q, out_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              busy_q, busy_d;
    logic              fall_seen_q, fall_seen_d;
    logic              rv_seen_q, rv_seen_d;
    logic              tmo;
    logic              got_fall;
    logic              got_rv;

    assign tmo      = (state_q != StIdle) && (cnt_q == TMO_LAST);
    assign got_fall = fall | fall_seen_q;
    assign got_rv   = reg_rvalid | rv_seen_q;

    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        err_d       = err_q;
        oe_d        = oe_q;
        out_d       = out_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        fall_seen_d = fall_seen_q;
        rv_seen_d   = rv_seen_q;

        if (!ena) begin
            state_d = StIdle;
            ack_d   = 1'b0;
            oe_d    = OE_REL;
        end else if (tmo) begin
            // Timeout takes priority over any coincident strobe edge.
            state_d = StIdle;
            ack_d   = 1'b0;
            oe_d    = OE_REL;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        addr_d = uio_in[ADDR_W-1:0];
                        err_d  = 1'b0;
                        ack_d  = 1'b1;
                        if (uio_in[CMD_WR_BIT]) begin
                            state_d = StCmdHold;
                        end else begin
                            re_d    = 1'b1;
                            state_d = StRdReq;
                        end
                    end
                end
                StCmdHold: begin
                    if (fall) begin
                        ack_d   = 1'b0;
                        state_d = StWrWait;
                    end
                end
                StWrWait: begin
                    if (rise) begin
                        wdata_d = uio_in;
                        we_d    = 1'b1;
                        ack_d   = 1'b1;
                        state_d = StWrHold;
                    end
                end
                StWrHold: begin
                    if (fall) begin
                        ack_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
                StRdReq: begin
                    if (reg_rvalid) begin
                        rdata_d   = reg_rdata;
                        rv_seen_d = 1'b1;
                    end
                    if (fall) begin
                        ack_d       = 1'b0;
                        fall_seen_d = 1'b1;
                    end
                    if (got_fall && got_rv) begin
                        state_d = StRdWait;
                    end
                end
                StRdWait: begin
                    if (rise) begin
                        out_d   = rdata_q;
                        oe_d    = OE_DRIVE;
                        ack_d   = 1'b1;
                        state_d = StRdDrive;
                    end
                end
                StRdDrive: begin
                    if (fall) begin
                        oe_d    = OE_REL;
                        ack_d   = 1'b0;
                        state_d = StRdTurn;
                    end
                end
                StRdTurn: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    ack_d   = 1'b0;
                    oe_d    = OE_REL;
                end
            endcase
        end

        if (state_d != StRdReq) begin
            fall_seen_d = 1'b0;
            rv_seen_d   = 1'b0;
        end

        if ((state_q == StIdle) || (state_d != state_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            oe_q        <= OE_REL;
            out_q       <= 8'h00;
            rdata_q     <= 8'h00;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            busy_q      <= 1'b0;
            fall_seen_q <= 1'b0;
            rv_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            oe_q        <= oe_d;
            out_q       <= out_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            busy_q      <= busy_d;
            fall_seen_q <= fall_seen_d;
            rv_seen_q   <= rv_seen_d;
        end
    end

    assign uio_out   = out_q;
    assign uio_oe    = oe_q;
    assign host_ack  = ack_q;
    assign host_err  = err_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uio_bus_ctrl.sv
// Directed bench for uio_bus_ctrl: writes, reads with late and coincident rvalid, timeout,
// ena drop and asynchronous reset.
module tb_uio_bus_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       host_stb;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       host_ack;
    logic       host_err;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       reg_rvalid;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    uio_bus_ctrl #(
        .ADDR_W (4),
        .TMO_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .host_stb   (host_stb),
        .uio_in     (uio_in),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .host_ack   (host_ack),
        .host_err   (host_err),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"},  {24'd0, uio_out}, 32'h0);
        check({tag, "_oe"},   {24'd0, uio_oe}, 32'h0);
        check({tag, "_ack"},  {31'd0, host_ack}, 32'h0);
        check({tag, "_err"},  {31'd0, host_err}, 32'h0);
        check({tag, "_addr"}, {28'd0, reg_addr}, 32'h0);
        check({tag, "_wdat"}, {24'd0, reg_wdata}, 32'h0);
        check({tag, "_we"},   {31'd0, reg_we}, 32'h0);
        check({tag, "_re"},   {31'd0, reg_re}, 32'h0);
        check({tag, "_busy"}, {31'd0, busy}, 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        host_stb   = 1'b0;
        uio_in     = 8'h00;
        reg_rdata  = 8'h00;
        reg_rvalid = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Write: cmd 0x83, data 0xA5
        uio_in = 8'h83; host_stb = 1'b1;
        tick(2);
        check("wr_cmd_ack_early", {31'd0, host_ack}, 32'h0);
        tick(1);
        check("wr_cmd_ack", {31'd0, host_ack}, 32'h1);
        check("wr_cmd_busy", {31'd0, busy}, 32'h1);
        check("wr_cmd_addr", {28'd0, reg_addr}, 32'h3);
        check("wr_cmd_re", {31'd0, reg_re}, 32'h0);
        host_stb = 1'b0;
        tick(2);
        check("wr_cmd_ack_hold", {31'd0, host_ack}, 32'h1);
        tick(1);
        check("wr_cmd_ack_drop", {31'd0, host_ack}, 32'h0);
        uio_in = 8'hA5; host_stb = 1'b1;
        tick(2);
        check("wr_we_early", {31'd0, reg_we}, 32'h0);
        tick(1);
        check("wr_we", {31'd0, reg_we}, 32'h1);
        check("wr_wdata", {24'd0, reg_wdata}, 32'hA5);
        check("wr_addr", {28'd0, reg_addr}, 32'h3);
        check("wr_dat_ack", {31'd0, host_ack}, 32'h1);
        tick(1);
        check("wr_we_pulse_end", {31'd0, reg_we}, 32'h0);
        check("wr_wdata_hold", {24'd0, reg_wdata}, 32'hA5);
        host_stb = 1'b0; uio_in = 8'h00;
        tick(3);
        check("wr_end_ack", {31'd0, host_ack}, 32'h0);
        check("wr_end_busy", {31'd0, busy}, 32'h0);

        // Read with rvalid arriving after the command fall
        uio_in = 8'h05; host_stb = 1'b1;
        tick(3);
        check("rd1_ack", {31'd0, host_ack}, 32'h1);
        check("rd1_re", {31'd0, reg_re}, 32'h1);
        check("rd1_addr", {28'd0, reg_addr}, 32'h5);
        tick(1);
        check("rd1_re_pulse_end", {31'd0, reg_re}, 32'h0);
        host_stb = 1'b0; uio_in = 8'h00;
        tick(3);
        check("rd1_ack_drop", {31'd0, host_ack}, 32'h0);
        check("rd1_busy_wait_rv", {31'd0, busy}, 32'h1);
        tick(1);
        reg_rvalid = 1'b1; reg_rdata = 8'h3C;
        tick(1);
        reg_rvalid = 1'b0; reg_rdata = 8'h00;
        check("rd1_oe_before_data", {24'd0, uio_oe}, 32'h0);
        host_stb = 1'b1;
        tick(2);
        check("rd1_oe_early", {24'd0, uio_oe}, 32'h0);
        tick(1);
        check("rd1_oe", {24'd0, uio_oe}, 32'hFF);
        check("rd1_out", {24'd0, uio_out}, 32'h3C);
        check("rd1_data_ack", {31'd0, host_ack}, 32'h1);
        host_stb = 1'b0;
        tick(2);
        check("rd1_oe_hold", {24'd0, uio_oe}, 32'hFF);
        tick(1);
        check("rd1_oe_rel", {24'd0, uio_oe}, 32'h0);
        check("rd1_ack_rel", {31'd0, host_ack}, 32'h0);
        check("rd1_turn_busy", {31'd0, busy}, 32'h1);
        check("rd1_out_kept", {24'd0, uio_out}, 32'h3C);
        tick(1);
        check("rd1_idle", {31'd0, busy}, 32'h0);

        // Read with rvalid coincident with the command fall
        uio_in = 8'h06; host_stb = 1'b1;
        tick(3);
        check("rd2_re", {31'd0, reg_re}, 32'h1);
        host_stb = 1'b0; uio_in = 8'h00;
        tick(2);
        reg_rvalid = 1'b1; reg_rdata = 8'h5A;
        tick(1);
        reg_rvalid = 1'b0; reg_rdata = 8'h00;
        check("rd2_ack_drop", {31'd0, host_ack}, 32'h0);
        host_stb = 1'b1;
        tick(3);
        check("rd2_oe", {24'd0, uio_oe}, 32'hFF);
        check("rd2_out", {24'd0, uio_out}, 32'h5A);

        // Drop ena in RD_DRIVE, then raise it with the strobe still high
        ena = 1'b0;
        tick(1);
        check("ena_oe", {24'd0, uio_oe}, 32'h0);
        check("ena_ack", {31'd0, host_ack}, 32'h0);
        check("ena_busy", {31'd0, busy}, 32'h0);
        tick(2);
        ena = 1'b1;
        tick(4);
        check("ena_no_cmd_ack", {31'd0, host_ack}, 32'h0);
        check("ena_no_cmd_busy", {31'd0, busy}, 32'h0);
        host_stb = 1'b0;
        tick(3);
        check("ena_fall_idle", {31'd0, busy}, 32'h0);

        // Read to RD_DRIVE, then asynchronous reset
        uio_in = 8'h09; host_stb = 1'b1;
        tick(3);
        check("rd3_re", {31'd0, reg_re}, 32'h1);
        host_stb = 1'b0; uio_in = 8'h00;
        reg_rvalid = 1'b1; reg_rdata = 8'hC3;
        tick(1);
        reg_rvalid = 1'b0; reg_rdata = 8'h00;
        tick(2);
        host_stb = 1'b1;
        tick(3);
        check("rd3_oe", {24'd0, uio_oe}, 32'hFF);
        check("rd3_out", {24'd0, uio_out}, 32'hC3);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        host_stb = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Timeout in WR_WAIT
        uio_in = 8'h8F; host_stb = 1'b1;
        tick(3);
        check("to_cmd_ack", {31'd0, host_ack}, 32'h1);
        host_stb = 1'b0;
        tick(3);
        check("to_in_wrwait", {31'd0, host_ack}, 32'h0);
        tick(250);
        check("to_busy_before", {31'd0, busy}, 32'h1);
        check("to_err_before", {31'd0, host_err}, 32'h0);
        tick(10);
        check("to_busy_after", {31'd0, busy}, 32'h0);
        check("to_err_after", {31'd0, host_err}, 32'h1);
        check("to_ack_after", {31'd0, host_ack}, 32'h0);
        tick(3);
        check("to_err_sticky", {31'd0, host_err}, 32'h1);
        uio_in = 8'h01; host_stb = 1'b1;
        tick(3);
        check("to_err_clear", {31'd0, host_err}, 32'h0);
        check("to_next_ack", {31'd0, host_ack}, 32'h1);
        check("to_next_re", {31'd0, reg_re}, 32'h1);
        check("to_next_addr", {28'd0, reg_addr}, 32'h1);
        host_stb = 1'b0; uio_in = 8'h00;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
